alarm_ctrl: RTL and testbench
=============================

Name: alarm_ctrl

Overview:
- Downstream consumer of the seconds-since-midnight counter (0 = 12:00:00 AM, 86399 = 11:59:59 PM).
- Holds the alarm setpoint and arms/disarms the alarm. Runs a ring/snooze/dismiss state machine.
- Drives the one-bit alarm flag consumed by the output formatter.
- Setpoint loads via a valid/ready handshake from the user-input side.

Parameters:
- COUNTER_MAX, 86399, last valid counter value (seconds per day minus one)
- SNOOZE_SECS, 540, snooze delay in seconds (9 min); legal range 1..COUNTER_MAX
- RING_TIMEOUT_SECS, 3600, seconds of unattended ringing before auto-dismiss; legal range 1..65535

Ports:
- clock  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high; all state cleared while high
- counter_state  in  17  current timestamp from the counter, 0..COUNTER_MAX
- set_valid  in  1  setpoint load request
- set_value  in  17  requested setpoint
- set_ready  out  1  block can accept a setpoint this cycle
- set_error  out  1  one-cycle pulse: handshake completed but set_value > COUNTER_MAX
- enable_toggle  in  1  one-cycle pulse: arm if disabled, else disable
- snooze  in  1  one-cycle pulse
- dismiss  in  1  one-cycle pulse
- alarm_setpoint  out  17  current setpoint
- alarm_armed  out  1  high in ARMED, RINGING, SNOOZED
- alarm_state  out  1  high only in RINGING

Behaviour:
- Reset values:
  - state DISABLED; alarm_setpoint 0.
  - alarm_state 0, alarm_armed 0, set_error 0.
  - set_ready 1; snooze target 0; ring counter 0; prev_valid 0.
- New-second detect:
  - prev register samples counter_state every cycle.
  - new_sec = prev_valid && (counter_state != prev). prev_valid sets on the first clock after reset.
  - No new_sec is possible on the first post-reset cycle.
- Wrap 86399->0 is an ordinary change. Equality tests fire only on new_sec.
- Time jumps past a target do not trigger; only exact equality triggers.
- States and transitions: all registered, with outputs Moore from state. alarm_state rises on the same edge that samples the matching counter_state.
  - DISABLED: enable_toggle -> ARMED.
  - ARMED: new_sec && counter_state == alarm_setpoint -> RINGING; ring counter cleared to 0.
  - RINGING:
    - dismiss -> ARMED.
    - else snooze -> SNOOZED, with snooze target = (counter_state + SNOOZE_SECS) mod 86400.
    - else new_sec increments the ring counter. Reaching RING_TIMEOUT_SECS -> ARMED.
  - SNOOZED: dismiss -> ARMED; new_sec && counter_state == snooze target -> RINGING, ring counter cleared to 0.
  - Any state except DISABLED: enable_toggle -> DISABLED.
- Priority when pulses coincide on the same edge: enable_toggle > dismiss > snooze > time match.
- Setpoint handshake:
  - set_ready = (state is DISABLED or ARMED). Transfer occurs when set_valid && set_ready.
  - If set_value <= COUNTER_MAX: alarm_setpoint updates on that edge.
  - Otherwise: set_error pulses for one cycle and the setpoint is unchanged.
  - set_valid while set_ready is low: ignored; the requester holds it.
  - Setpoint load and time match on the same edge in ARMED: the match uses the old setpoint.
- Mod arithmetic: compute the 18-bit sum; subtract 86400 if the sum is >= 86400. No division.
- Reset asserted mid-RINGING: alarm_state drops asynchronously; the setpoint is lost (returns to 0).

Decomposition:
- Shared package contents:
  - COUNTER_T (17-bit unsigned) and FLAG_T (1-bit).
  - COUNTER_MAX and SECS_PER_DAY (86400).
  - The 2-bit alarm state encoding: DISABLED=0, ARMED=1, RINGING=2, SNOOZED=3.
  - The mod-86400 add function.
- One sub-module: sec_tick_detect (prev register, prev_valid, new_sec output). It is reusable by other per-second consumers.

Test Plan:
- Arm and match: reset, load setpoint 25200, toggle enable, ramp counter 25198->25201 -> alarm_state 1 from the edge sampling 25200; armed 1.
- Snooze wrap: setpoint 86000, ring, snooze at counter 86100 -> SNOOZED, target 240. Ramp through 86399->0->240 -> rings again at 240.
- Timeout and dismiss priority:
  - Ring with no input for 3600 new seconds -> ARMED, alarm_state 0.
  - Separately, snooze and dismiss on the same edge -> ARMED.
- Handshake:
  - set_value 90000 -> set_error pulse, setpoint unchanged.
  - set_valid during RINGING -> set_ready 0, no update.
  - Load and match on the same edge -> old setpoint matches.
- Jump and hold: counter steps 100->300 with setpoint 200 -> no ring. Counter held at the setpoint for 10 clocks after ARMED -> rings only on a change into the value.
- Async reset mid-RINGING -> alarm_state 0 immediately, setpoint 0. The first post-reset cycle with counter == 0 -> no ring.

Source files
------------

// File: rtl/alarm_ctrl_pkg.sv
// Shared types, constants and time-of-day arithmetic for the alarm controller
// and other consumers of the seconds-since-midnight counter.
package alarm_ctrl_pkg;

  typedef logic [16:0] counter_t;
  typedef logic        flag_t;

  localparam counter_t    COUNTER_MAX  = 17'd86399;
  localparam logic [17:0] SECS_PER_DAY = 18'd86400;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZED  = 2'd3
  } alarm_state_e;

  // Time-of-day add without a divider: both operands are below one day, so
  // a single conditional subtract is enough.
  function automatic counter_t mod_day_add(input counter_t a, input counter_t b);
    logic [17:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= SECS_PER_DAY) sum = sum - SECS_PER_DAY;
    return sum[16:0];
  endfunction

endpackage

// File: rtl/alarm_ctrl_sec_tick_detect.sv
// Flags the cycle on which the seconds counter takes a new value. Usable by
// any per-second consumer of the counter.
module sec_tick_detect
  import alarm_ctrl_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  counter_t count,
  output flag_t    new_sec
);

  counter_t prev;
  logic     prev_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else begin
      prev       <= count;
      prev_valid <= 1'b1;
    end
  end

  // prev is meaningless until it has sampled once, hence the qualifier.
  assign new_sec = prev_valid && (count != prev);

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm setpoint holder and ring/snooze/dismiss state machine driving the
// alarm flag for the output formatter.
module alarm_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter int unsigned SNOOZE_SECS       = 540,
  parameter int unsigned RING_TIMEOUT_SECS = 3600
) (
  input  logic     clock,
  input  logic     reset,
  input  counter_t counter_state,
  input  logic     set_valid,
  input  counter_t set_value,
  output logic     set_ready,
  output flag_t    set_error,
  input  logic     enable_toggle,
  input  logic     snooze,
  input  logic     dismiss,
  output counter_t alarm_setpoint,
  output flag_t    alarm_armed,
  output flag_t    alarm_state
);

  localparam counter_t    SNOOZE_DELAY = counter_t'(SNOOZE_SECS);
  localparam logic [15:0] RING_LAST    = 16'(RING_TIMEOUT_SECS - 1);

  alarm_state_e state, state_n;
  logic [15:0]  ring_cnt, ring_cnt_n;
  counter_t     snooze_tgt, snooze_tgt_n;
  flag_t        new_sec;
  logic         set_fire;

  sec_tick_detect u_tick (
    .clock   (clock),
    .reset   (reset),
    .count   (counter_state),
    .new_sec (new_sec)
  );

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_n      = state;
    ring_cnt_n   = ring_cnt;
    snooze_tgt_n = snooze_tgt;
    if (enable_toggle) begin
      state_n = (state == ST_DISABLED) ? ST_ARMED : ST_DISABLED;
    end else begin
      case (state)
        ST_ARMED: begin
          if (new_sec && counter_state == alarm_setpoint) begin
            state_n    = ST_RINGING;
            ring_cnt_n = '0;
          end
        end
        ST_RINGING: begin
          if (dismiss) begin
            state_n = ST_ARMED;
          end else if (snooze) begin
            state_n      = ST_SNOOZED;
            snooze_tgt_n = mod_day_add(counter_state, SNOOZE_DELAY);
          end else if (new_sec) begin
            if (ring_cnt == RING_LAST) state_n = ST_ARMED;
            else ring_cnt_n = ring_cnt + 16'd1;
          end
        end
        ST_SNOOZED: begin
          if (dismiss) begin
            state_n = ST_ARMED;
          end else if (new_sec && counter_state == snooze_tgt) begin
            state_n    = ST_RINGING;
            ring_cnt_n = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_DISABLED;
      ring_cnt   <= '0;
      snooze_tgt <= '0;
    end else begin
      state      <= state_n;
      ring_cnt   <= ring_cnt_n;
      snooze_tgt <= snooze_tgt_n;
    end
  end

  // The match above reads the pre-edge setpoint, so a load on the same edge
  // never affects that edge's comparison.
  assign set_ready = (state == ST_DISABLED) || (state == ST_ARMED);
  assign set_fire  = set_valid && set_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alarm_setpoint <= '0;
      set_error      <= 1'b0;
    end else begin
      set_error <= set_fire && (set_value > COUNTER_MAX);
      if (set_fire && set_value <= COUNTER_MAX) alarm_setpoint <= set_value;
    end
  end

  assign alarm_armed = (state != ST_DISABLED);
  assign alarm_state = (state == ST_RINGING);

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed-vector bench for alarm_ctrl: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_alarm_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [16:0] counter_state;
  logic        set_valid;
  logic [16:0] set_value;
  logic        set_ready;
  logic        set_error;
  logic        enable_toggle;
  logic        snooze;
  logic        dismiss;
  logic [16:0] alarm_setpoint;
  logic        alarm_armed;
  logic        alarm_state;

  int errors = 0;
  int checks = 0;

  alarm_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .counter_state  (counter_state),
    .set_valid      (set_valid),
    .set_value      (set_value),
    .set_ready      (set_ready),
    .set_error      (set_error),
    .enable_toggle  (enable_toggle),
    .snooze         (snooze),
    .dismiss        (dismiss),
    .alarm_setpoint (alarm_setpoint),
    .alarm_armed    (alarm_armed),
    .alarm_state    (alarm_state)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset(input logic [16:0] cnt);
    reset         = 1'b1;
    counter_state = cnt;
    set_valid     = 1'b0;
    set_value     = '0;
    enable_toggle = 1'b0;
    snooze        = 1'b0;
    dismiss       = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic load(input logic [16:0] v);
    set_valid = 1'b1;
    set_value = v;
    tick();
    set_valid = 1'b0;
  endtask

  task automatic toggle_enable();
    enable_toggle = 1'b1;
    tick();
    enable_toggle = 1'b0;
  endtask

  task automatic step_to(input logic [16:0] v);
    counter_state = v;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++; if (alarm_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b expected 0", alarm_state); end
    checks++; if (alarm_armed !== 1'b0) begin errors++; $display("FAIL reset_armed: got %b expected 0", alarm_armed); end
    checks++; if (set_error !== 1'b0) begin errors++; $display("FAIL reset_set_error: got %b expected 0", set_error); end
    checks++; if (set_ready !== 1'b1) begin errors++; $display("FAIL reset_set_ready: got %b expected 1", set_ready); end
    checks++; if (alarm_setpoint !== 17'd0) begin errors++; $display("FAIL reset_setpoint: got %0d expected 0", alarm_setpoint); end
  endtask

  task automatic test_arm_match();
    do_reset(17'd25198);
    load(17'd25200);
    checks++; if (alarm_setpoint !== 17'd25200) begin errors++; $display("FAIL arm_load: got %0d expected 25200", alarm_setpoint); end
    toggle_enable();
    checks++; if (alarm_armed !== 1'b1) begin errors++; $display("FAIL arm_armed: got %b expected 1", alarm_armed); end
    step_to(17'd25199);
    checks++; if (alarm_state !== 1'b0) begin errors++; $display("FAIL arm_before: got %b expected 0", alarm_state); end
    step_to(17'd25200);
    checks++; if (alarm_state !== 1'b1) begin errors++; $display("FAIL arm_match: got %b expected 1", alarm_state); end
    step_to(17'd25201);
    checks++; if (alarm_state !== 1'b1 || alarm_armed !== 1'b1) begin errors++; $display("FAIL arm_after: got state=%b armed=%b expected 1 1", alarm_state, alarm_armed); end
  endtask

  task automatic test_snooze_wrap();
    logic early;
    do_reset(17'd85999);
    load(17'd86000);
    toggle_enable();
    step_to(17'd86000);
    checks++; if (alarm_state !== 1'b1) begin errors++; $display("FAIL snz_ring: got %b expected 1", alarm_state); end
    snooze = 1'b1;
    step_to(17'd86100);
    snooze = 1'b0;
    checks++; if (alarm_state !== 1'b0 || alarm_armed !== 1'b1) begin errors++; $display("FAIL snz_enter: got state=%b armed=%b expected 0 1", alarm_state, alarm_armed); end
    checks++; if (set_ready !== 1'b0) begin errors++; $display("FAIL snz_ready: got %b expected 0", set_ready); end
    early = 1'b0;
    for (int v = 86101; v <= 86399; v++) begin
      step_to(17'(v));
      if (alarm_state !== 1'b0) early = 1'b1;
    end
    for (int v = 0; v <= 239; v++) begin
      step_to(17'(v));
      if (alarm_state !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL snz_early: got early_ring=%b expected 0", early); end
    step_to(17'd240);
    checks++; if (alarm_state !== 1'b1) begin errors++; $display("FAIL snz_wrap_ring: got %b expected 1", alarm_state); end
  endtask

  task automatic test_timeout();
    logic dropped;
    do_reset(17'd999);
    load(17'd1000);
    toggle_enable();
    step_to(17'd1000);
    checks++; if (alarm_state !== 1'b1) begin errors++; $display("FAIL to_ring: got %b expected 1", alarm_state); end
    dropped = 1'b0;
    for (int i = 1; i <= 3599; i++) begin
      step_to(17'(1000 + i));
      if (alarm_state !== 1'b1) dropped = 1'b1;
    end
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL to_early: got dropped=%b expected 0", dropped); end
    step_to(17'd4600);
    checks++; if (alarm_state !== 1'b0 || alarm_armed !== 1'b1) begin errors++; $display("FAIL to_expire: got state=%b armed=%b expected 0 1", alarm_state, alarm_armed); end
  endtask

  task automatic test_priority();
    do_reset(17'd49);
    load(17'd50);
    toggle_enable();
    step_to(17'd50);
    checks++; if (alarm_state !== 1'b1) begin errors++; $display("FAIL pri_ring: got %b expected 1", alarm_state); end
    snooze  = 1'b1;
    dismiss = 1'b1;
    tick();
    snooze  = 1'b0;
    dismiss = 1'b0;
    checks++; if (alarm_state !== 1'b0 || alarm_armed !== 1'b1 || set_ready !== 1'b1) begin
      errors++; $display("FAIL pri_dismiss: got state=%b armed=%b ready=%b expected 0 1 1", alarm_state, alarm_armed, set_ready);
    end
    step_to(17'd51);
    step_to(17'd50);
    checks++; if (alarm_state !== 1'b1) begin errors++; $display("FAIL pri_reRing: got %b expected 1", alarm_state); end
    enable_toggle = 1'b1;
    dismiss       = 1'b1;
    tick();
    enable_toggle = 1'b0;
    dismiss       = 1'b0;
    checks++; if (alarm_state !== 1'b0 || alarm_armed !== 1'b0) begin errors++; $display("FAIL pri_toggle: got state=%b armed=%b expected 0 0", alarm_state, alarm_armed); end
  endtask

  task automatic test_handshake();
    do_reset(17'd10);
    load(17'd500);
    set_valid = 1'b1;
    set_value = 17'd90000;
    tick();
    set_valid = 1'b0;
    checks++; if (set_error !== 1'b1) begin errors++; $display("FAIL hs_err_pulse: got %b expected 1", set_error); end
    checks++; if (alarm_setpoint !== 17'd500) begin errors++; $display("FAIL hs_err_keep: got %0d expected 500", alarm_setpoint); end
    tick();
    checks++; if (set_error !== 1'b0) begin errors++; $display("FAIL hs_err_clear: got %b expected 0", set_error); end
    toggle_enable();
    step_to(17'd499);
    step_to(17'd500);
    checks++; if (alarm_state !== 1'b1 || set_ready !== 1'b0) begin errors++; $display("FAIL hs_ring_ready: got state=%b ready=%b expected 1 0", alarm_state, set_ready); end
    set_valid = 1'b1;
    set_value = 17'd700;
    tick(2);
    checks++; if (alarm_setpoint !== 17'd500) begin errors++; $display("FAIL hs_blocked: got %0d expected 500", alarm_setpoint); end
    dismiss = 1'b1;
    tick();
    dismiss = 1'b0;
    checks++; if (alarm_setpoint !== 17'd500 || set_ready !== 1'b1) begin errors++; $display("FAIL hs_dismiss: got sp=%0d ready=%b expected 500 1", alarm_setpoint, set_ready); end
    tick();
    set_valid = 1'b0;
    checks++; if (alarm_setpoint !== 17'd700) begin errors++; $display("FAIL hs_held_load: got %0d expected 700", alarm_setpoint); end
    step_to(17'd699);
    set_valid = 1'b1;
    set_value = 17'd800;
    step_to(17'd700);
    set_valid = 1'b0;
    checks++; if (alarm_state !== 1'b1) begin errors++; $display("FAIL hs_old_match: got %b expected 1", alarm_state); end
    checks++; if (alarm_setpoint !== 17'd800) begin errors++; $display("FAIL hs_same_edge_load: got %0d expected 800", alarm_setpoint); end
  endtask

  task automatic test_jump_hold();
    logic rang;
    do_reset(17'd100);
    load(17'd200);
    toggle_enable();
    step_to(17'd300);
    tick();
    checks++; if (alarm_state !== 1'b0 || alarm_armed !== 1'b1) begin errors++; $display("FAIL jump_no_ring: got state=%b armed=%b expected 0 1", alarm_state, alarm_armed); end
    do_reset(17'd200);
    load(17'd200);
    toggle_enable();
    rang = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (alarm_state !== 1'b0) rang = 1'b1;
    end
    checks++; if (rang !== 1'b0) begin errors++; $display("FAIL hold_no_ring: got rang=%b expected 0", rang); end
    step_to(17'd199);
    step_to(17'd200);
    checks++; if (alarm_state !== 1'b1) begin errors++; $display("FAIL hold_change_in: got %b expected 1", alarm_state); end
  endtask

  task automatic test_async_reset();
    logic rang;
    do_reset(17'd5);
    load(17'd6);
    toggle_enable();
    step_to(17'd6);
    checks++; if (alarm_state !== 1'b1) begin errors++; $display("FAIL ar_ring: got %b expected 1", alarm_state); end
    #2;
    reset         = 1'b1;
    counter_state = 17'd0;
    #1;
    checks++; if (alarm_state !== 1'b0) begin errors++; $display("FAIL ar_async_drop: got %b expected 0", alarm_state); end
    checks++; if (alarm_setpoint !== 17'd0 || alarm_armed !== 1'b0) begin errors++; $display("FAIL ar_cleared: got sp=%0d armed=%b expected 0 0", alarm_setpoint, alarm_armed); end
    #2;
    reset         = 1'b0;
    enable_toggle = 1'b1;
    tick();
    enable_toggle = 1'b0;
    rang = alarm_state;
    tick(3);
    if (alarm_state !== 1'b0) rang = 1'b1;
    checks++; if (rang !== 1'b0 || alarm_armed !== 1'b1) begin errors++; $display("FAIL ar_first_cycle: got rang=%b armed=%b expected 0 1", rang, alarm_armed); end
  endtask

  initial begin
    reset         = 1'b1;
    counter_state = '0;
    set_valid     = 1'b0;
    set_value     = '0;
    enable_toggle = 1'b0;
    snooze        = 1'b0;
    dismiss       = 1'b0;
    test_reset();
    test_arm_match();
    test_snooze_wrap();
    test_timeout();
    test_priority();
    test_handshake();
    test_jump_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
